mbist_data_decoder: RTL and testbench

//  Maps a 3-bit MBIST background-select code to the data background word that
//  the MBIST controller writes to and compares against the memory under test.
//  The pattern output is registered for one cycle of latency. The block sits

---
 rtl/mbist_data_decoder.sv | 69 ++++++
 tb/tb_mbist_data_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mbist_data_decoder.sv
// MBIST data background decoder: registers a per-byte background pattern selected
// by a 3-bit code and replicates it across the data word; illegal codes flag sel_err.
module mbist_data_decoder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            q,
  input  logic                  q_valid,
  output logic [DATA_WIDTH-1:0] data_t,
  output logic                  data_valid,
  output logic                  sel_err
);

  // DATA_WIDTH must be a multiple of 8; any remainder bits would be left at zero.
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [7:0]            byte_pat_d;
  logic                  sel_err_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;
  logic                  sel_err_q;

  always_comb begin
    byte_pat_d = 8'h00;
    sel_err_d  = 1'b0;
    case (q)
      3'b000:  byte_pat_d = 8'b1010_1010;
      3'b001:  byte_pat_d = 8'b0101_0101;
      3'b010:  byte_pat_d = 8'b1111_0000;
      3'b011:  byte_pat_d = 8'b0000_1111;
      3'b100:  byte_pat_d = 8'b0000_0000;
      3'b101:  byte_pat_d = 8'b1111_1111;
      default: begin
        byte_pat_d = 8'h00;
        sel_err_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < NBYTES; i++) begin
      data_d[i*8 +: 8] = byte_pat_d;
    end
  end

  // data_t holds across idle cycles; the valid/error strobes only mark fresh loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else if (q_valid) begin
      data_q       <= data_d;
      data_valid_q <= 1'b1;
      sel_err_q    <= sel_err_d;
    end else begin
      data_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end
  end

  assign data_t     = data_q;
  assign data_valid = data_valid_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_mbist_data_decoder.sv
// Bench for mbist_data_decoder: 8- and 32-bit instances checked every cycle against
// a table-driven model, plus hand-computed literal expectations.
module tb_mbist_data_decoder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  q;
  logic        q_valid;
  logic [7:0]  data8;
  logic        dv8;
  logic        err8;
  logic [31:0] data32;
  logic        dv32;
  logic        err32;

  int checks;
  int failures;
  bit cmp_en;

  mbist_data_decoder #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .q(q), .q_valid(q_valid),
    .data_t(data8), .data_valid(dv8), .sel_err(err8)
  );

  mbist_data_decoder #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .q(q), .q_valid(q_valid),
    .data_t(data32), .data_valid(dv32), .sel_err(err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pattern table indexed by code, replicated by concatenation.
  logic [7:0]  pat_tab [8];
  logic [31:0] m_data32;
  logic [7:0]  m_data8;
  logic        m_valid;
  logic        m_err;

  initial begin
    pat_tab[0] = 8'hAA; pat_tab[1] = 8'h55; pat_tab[2] = 8'hF0; pat_tab[3] = 8'h0F;
    pat_tab[4] = 8'h00; pat_tab[5] = 8'hFF; pat_tab[6] = 8'h00; pat_tab[7] = 8'h00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data8  <= 8'h00;
      m_data32 <= 32'h0;
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
    end else if (q_valid) begin
      m_data8  <= pat_tab[q];
      m_data32 <= {4{pat_tab[q]}};
      m_valid  <= 1'b1;
      m_err    <= (q > 3'd5);
    end else begin
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_data8", {24'h0, data8}, {24'h0, m_data8});
      chk("cyc_dv8", {31'h0, dv8}, {31'h0, m_valid});
      chk("cyc_err8", {31'h0, err8}, {31'h0, m_err});
      chk("cyc_data32", data32, m_data32);
      chk("cyc_dv32", {31'h0, dv32}, {31'h0, m_valid});
      chk("cyc_err32", {31'h0, err32}, {31'h0, m_err});
      $display("cycle t=%0t rst_n=%0b q=%0d qv=%0b data8=%h data32=%h dv=%0b err=%0b",
               $time, rst_n, q, q_valid, data8, data32, dv8, err8);
    end
  end

  // Apply inputs just after an edge; outputs are checked 1 time unit after the next edge.
  task automatic step(input logic [2:0] qq, input logic v);
    @(posedge clk);
    #1;
    q       = qq;
    q_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [6];

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    q        = 3'd0;
    q_valid  = 1'b1;
    sweep_exp[0] = 8'hAA; sweep_exp[1] = 8'h55; sweep_exp[2] = 8'hF0;
    sweep_exp[3] = 8'h0F; sweep_exp[4] = 8'h00; sweep_exp[5] = 8'hFF;

    // Reset held while clocking with a valid code present
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #1;
    chk("rst_data8", {24'h0, data8}, 32'h0);
    chk("rst_data32", data32, 32'h0);
    chk("rst_dv", {31'h0, dv8}, 32'h0);
    chk("rst_err", {31'h0, err8}, 32'h0);
    q_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Back-to-back sweep of legal codes
    @(posedge clk);
    #1;
    q_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q = 3'(i);
      @(posedge clk);
      #1;
      chk("sweep_data8", {24'h0, data8}, {24'h0, sweep_exp[i]});
      chk("sweep_dv", {31'h0, dv8}, 32'h1);
      chk("sweep_err", {31'h0, err8}, 32'h0);
    end

    // Illegal codes
    q = 3'b110;
    @(posedge clk);
    #1;
    chk("ill6_data8", {24'h0, data8}, 32'h0);
    chk("ill6_err", {31'h0, err8}, 32'h1);
    chk("ill6_dv", {31'h0, dv8}, 32'h1);
    q = 3'b111;
    @(posedge clk);
    #1;
    chk("ill7_data32", data32, 32'h0);
    chk("ill7_err", {31'h0, err32}, 32'h1);

    // Hold: load F0 then idle with a different code on q
    step(3'b010, 1'b1);
    chk("hold_load", {24'h0, data8}, 32'hF0);
    for (int i = 0; i < 3; i++) begin
      step(3'b101, 1'b0);
      chk("hold_data8", {24'h0, data8}, 32'hF0);
      chk("hold_dv", {31'h0, dv8}, 32'h0);
      chk("hold_err", {31'h0, err8}, 32'h0);
    end

    // Idle after an illegal load clears the error strobe
    step(3'b110, 1'b1);
    step(3'b000, 1'b0);
    chk("err_clear", {31'h0, err8}, 32'h0);
    chk("err_hold0", {24'h0, data8}, 32'h0);

    // 32-bit replication
    step(3'b000, 1'b1);
    chk("w32_aa", data32, 32'hAAAAAAAA);
    step(3'b011, 1'b1);
    chk("w32_0f", data32, 32'h0F0F0F0F);

    // Async reset between edges after loading FF
    step(3'b101, 1'b1);
    chk("pre_async8", {24'h0, data8}, 32'hFF);
    chk("pre_async32", data32, 32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data8", {24'h0, data8}, 32'h0);
    chk("async_data32", data32, 32'h0);
    chk("async_dv", {31'h0, dv8}, 32'h0);
    q_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Recovery load after reset
    step(3'b001, 1'b1);
    chk("recover_55", {24'h0, data8}, 32'h55);
    step(3'b001, 1'b0);
    @(posedge clk);
    #1;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
